// File: rtl/sipo_word_collector.sv
// sipo_word_collector
//
// Packs a single-bit serial stream into WIDTH-bit words. A shift register and
// a bit counter assemble the current word. A one-word output buffer with a
// valid/ready handshake decouples assembly from a stalling consumer.
//
// Parameters
//   WIDTH      word width in bits (2..32)
//   MSB_FIRST  1: first accepted bit ends up in dout[WIDTH-1]; 0: in dout[0]
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   din         serial data bit
//   din_valid   din carries a bit this cycle
//   din_ready   stage accepts din this cycle (transfer = din_valid && din_ready)
//   clear       synchronous flush of the partial word (output buffer untouched)
//   dout        assembled word, stable while dout_valid is high
//   dout_valid  output buffer holds a word
//   dout_ready  consumer takes the word (transfer = dout_valid && dout_ready)
//   bit_count   bits currently held in the shift register (0..WIDTH-1)
module sipo_word_collector #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     din,
    input  logic                     din_valid,
    output logic                     din_ready,
    input  logic                     clear,
    output logic [WIDTH-1:0]         dout,
    output logic                     dout_valid,
    input  logic                     dout_ready,
    output logic [$clog2(WIDTH)-1:0] bit_count
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } ob_state_t;

    ob_state_t        state_reg, state_next;
    logic [WIDTH-1:0] sr_reg, sr_next;
    logic [WIDTH-1:0] ob_reg, ob_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [WIDTH-1:0] sr_shift;

    logic full;
    logic last;
    logic accept;
    logic complete;
    logic pop;

    // Shift direction decides which end of the word the first bit lands in.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign sr_shift = {sr_reg[WIDTH-2:0], din};
        end else begin : g_lsb_first
            assign sr_shift = {din, sr_reg[WIDTH-1:1]};
        end
    endgenerate

    assign full = (state_reg == FULL);
    assign last = (cnt_reg == LAST_BIT);

    // Only the final bit of a word can stall: its completion needs the buffer,
    // which is free if empty or being drained in this very cycle.
    assign din_ready = !(last && full && !dout_ready);

    assign accept   = din_valid && din_ready;
    // clear outranks accept, so a bit arriving with clear never completes.
    assign complete = accept && last && !clear;
    assign pop      = full && dout_ready;

    always_comb begin
        state_next = state_reg;
        sr_next    = sr_reg;
        cnt_next   = cnt_reg;
        ob_next    = ob_reg;

        if (clear) begin
            sr_next  = '0;
            cnt_next = '0;
        end else if (accept) begin
            if (last) begin
                ob_next  = sr_shift;
                sr_next  = '0;
                cnt_next = '0;
            end else begin
                sr_next  = sr_shift;
                cnt_next = cnt_reg + CW'(1);
            end
        end

        case (state_reg)
            EMPTY: if (complete) state_next = FULL;
            // A pop coinciding with a completion keeps the buffer occupied
            // with the new word.
            FULL:  if (pop && !complete) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= EMPTY;
            sr_reg    <= '0;
            ob_reg    <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            sr_reg    <= sr_next;
            ob_reg    <= ob_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign dout       = ob_reg;
    assign dout_valid = full;
    assign bit_count  = cnt_reg;

endmodule

// File: tb/tb_sipo_word_collector.sv
// Testbench for sipo_word_collector. Two instances (MSB-first and LSB-first)
// share one stimulus; words handed to the stimulus are pushed to a scoreboard
// and popped whenever a word leaves the output handshake.
module tb_sipo_word_collector;

    logic       clk = 1'b0;
    logic       rst;
    logic       din;
    logic       din_valid;
    logic       clear;
    logic       dout_ready;
    logic       ready_m, ready_l;
    logic       valid_m, valid_l;
    logic [7:0] dout_m, dout_l;
    logic [2:0] bc_m, bc_l;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] exp_m[$];
    logic [7:0] exp_l[$];

    always #5 clk = ~clk;

    sipo_word_collector #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(ready_m),
        .clear(clear), .dout(dout_m), .dout_valid(valid_m), .dout_ready(dout_ready),
        .bit_count(bc_m)
    );

    sipo_word_collector #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(ready_l),
        .clear(clear), .dout(dout_l), .dout_valid(valid_l), .dout_ready(dout_ready),
        .bit_count(bc_l)
    );

    function automatic logic [7:0] rev8(input logic [7:0] w);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = w[7-i];
        return r;
    endfunction

    // Word w is sent first bit = w[7]; the LSB-first instance sees it reversed.
    task automatic push_word(input logic [7:0] w);
        exp_m.push_back(w);
        exp_l.push_back(rev8(w));
    endtask

    // One clock cycle: sample at the falling edge, pop the scoreboard if a word
    // leaves, then return just after the rising edge.
    task automatic tick();
        logic [7:0] em, el;
        @(negedge clk);
        if (valid_m && dout_ready) begin
            vectors++;
            if (exp_m.size() == 0) begin
                miscompares++;
                $display("FAIL scoreboard_unexpected_word: got msb=%h lsb=%h, expected no word", dout_m, dout_l);
            end else begin
                em = exp_m.pop_front();
                el = exp_l.pop_front();
                if (dout_m !== em || dout_l !== el || valid_l !== 1'b1) begin
                    miscompares++;
                    $display("FAIL scoreboard_word: got msb=%h lsb=%h vl=%b, expected msb=%h lsb=%h vl=1",
                             dout_m, dout_l, valid_l, em, el);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Sends nbits bits of w (w[7] first) on consecutive cycles; every bit must
    // be accepted immediately.
    task automatic send_bits(input logic [7:0] w, input int nbits);
        for (int i = 7; i > 7 - nbits; i--) begin
            din       = w[i];
            din_valid = 1'b1;
            #1;
            vectors++;
            if (ready_m !== 1'b1 || ready_l !== 1'b1) begin
                miscompares++;
                $display("FAIL send_ready bit%0d: got %b/%b, expected 1/1", i, ready_m, ready_l);
            end
            tick();
        end
        din_valid = 1'b0;
    endtask

    task automatic test_reset();
        vectors++;
        if (valid_m !== 1'b0 || dout_m !== 8'h00 || bc_m !== 3'd0 || ready_m !== 1'b1 ||
            valid_l !== 1'b0 || dout_l !== 8'h00 || bc_l !== 3'd0 || ready_l !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_state: got v=%b d=%h bc=%0d r=%b, expected v=0 d=00 bc=0 r=1",
                     valid_m, dout_m, bc_m, ready_m);
        end
    endtask

    task automatic test_msb_first();
        dout_ready = 1'b1;
        push_word(8'hB2);
        for (int i = 7; i >= 0; i--) begin
            din       = 8'hB2 >> i;
            din_valid = 1'b1;
            #1;
            vectors++;
            if (valid_m !== 1'b0) begin
                miscompares++;
                $display("FAIL msb_early_valid bit%0d: got %b, expected 0", i, valid_m);
            end
            tick();
        end
        din_valid = 1'b0;
        #1;
        vectors++;
        if (valid_m !== 1'b1 || dout_m !== 8'hB2) begin
            miscompares++;
            $display("FAIL msb_latency: got v=%b d=%h, expected v=1 d=b2", valid_m, dout_m);
        end
        tick();
        vectors++;
        if (valid_m !== 1'b0) begin
            miscompares++;
            $display("FAIL msb_valid_pulse: got %b, expected 0", valid_m);
        end
    endtask

    task automatic test_lsb_first();
        dout_ready = 1'b1;
        push_word(8'hB2);
        send_bits(8'hB2, 8);
        #1;
        vectors++;
        if (valid_l !== 1'b1 || dout_l !== 8'h4D) begin
            miscompares++;
            $display("FAIL lsb_word: got v=%b d=%h, expected v=1 d=4d", valid_l, dout_l);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [7:0] words[3];
        words[0] = 8'h5A;
        words[1] = 8'hC3;
        words[2] = 8'h81;
        dout_ready = 1'b1;
        for (int k = 0; k < 3; k++) push_word(words[k]);
        for (int k = 0; k < 3; k++) begin
            send_bits(words[k], 7);
            din       = words[k][0];
            din_valid = 1'b1;
            #1;
            vectors++;
            if (ready_m !== 1'b1 || bc_m !== 3'd7) begin
                miscompares++;
                $display("FAIL b2b_last_bit w%0d: got r=%b bc=%0d, expected r=1 bc=7", k, ready_m, bc_m);
            end
            tick();
            vectors++;
            if (valid_m !== 1'b1 || dout_m !== words[k] || bc_m !== 3'd0) begin
                miscompares++;
                $display("FAIL b2b_word w%0d: got v=%b d=%h bc=%0d, expected v=1 d=%h bc=0",
                         k, valid_m, dout_m, bc_m, words[k]);
            end
        end
        din_valid = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        dout_ready = 1'b0;
        push_word(8'hA5);
        push_word(8'h3C);
        send_bits(8'hA5, 8);
        send_bits(8'h3C, 7);
        din       = 1'b0;
        din_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            vectors++;
            if (ready_m !== 1'b0 || ready_l !== 1'b0 || valid_m !== 1'b1 || dout_m !== 8'hA5 || bc_m !== 3'd7) begin
                miscompares++;
                $display("FAIL bp_stall c%0d: got r=%b v=%b d=%h bc=%0d, expected r=0 v=1 d=a5 bc=7",
                         c, ready_m, valid_m, dout_m, bc_m);
            end
            tick();
        end
        dout_ready = 1'b1;
        #1;
        vectors++;
        if (ready_m !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_release_ready: got %b, expected 1", ready_m);
        end
        tick();
        din_valid  = 1'b0;
        dout_ready = 1'b0;
        #1;
        vectors++;
        if (valid_m !== 1'b1 || dout_m !== 8'h3C || dout_l !== rev8(8'h3C) || bc_m !== 3'd0) begin
            miscompares++;
            $display("FAIL bp_second_word: got v=%b d=%h bc=%0d, expected v=1 d=3c bc=0", valid_m, dout_m, bc_m);
        end
        dout_ready = 1'b1;
        tick();
    endtask

    task automatic test_simultaneous();
        dout_ready = 1'b0;
        push_word(8'h17);
        push_word(8'hE8);
        send_bits(8'h17, 8);
        send_bits(8'hE8, 7);
        din        = 1'b0;
        din_valid  = 1'b1;
        dout_ready = 1'b1;
        tick();
        din_valid  = 1'b0;
        dout_ready = 1'b0;
        #1;
        vectors++;
        if (valid_m !== 1'b1 || dout_m !== 8'hE8) begin
            miscompares++;
            $display("FAIL simul_new_word: got v=%b d=%h, expected v=1 d=e8", valid_m, dout_m);
        end
        dout_ready = 1'b1;
        tick();
        vectors++;
        if (valid_m !== 1'b0) begin
            miscompares++;
            $display("FAIL simul_drained: got %b, expected 0", valid_m);
        end
    endtask

    task automatic test_clear();
        dout_ready = 1'b0;
        push_word(8'h96);
        push_word(8'h69);
        send_bits(8'h96, 8);
        send_bits(8'hFF, 3);
        din       = 1'b1;
        din_valid = 1'b1;
        clear     = 1'b1;
        #1;
        vectors++;
        if (ready_m !== 1'b1 || bc_m !== 3'd3) begin
            miscompares++;
            $display("FAIL clear_pre: got r=%b bc=%0d, expected r=1 bc=3", ready_m, bc_m);
        end
        tick();
        clear     = 1'b0;
        din_valid = 1'b0;
        #1;
        vectors++;
        if (bc_m !== 3'd0 || bc_l !== 3'd0 || valid_m !== 1'b1 || dout_m !== 8'h96) begin
            miscompares++;
            $display("FAIL clear_post: got bc=%0d v=%b d=%h, expected bc=0 v=1 d=96", bc_m, valid_m, dout_m);
        end
        dout_ready = 1'b1;
        tick();
        send_bits(8'h69, 8);
        #1;
        vectors++;
        if (valid_m !== 1'b1 || dout_m !== 8'h69) begin
            miscompares++;
            $display("FAIL clear_next_word: got v=%b d=%h, expected v=1 d=69", valid_m, dout_m);
        end
        tick();
    endtask

    task automatic test_reset_midword();
        dout_ready = 1'b0;
        push_word(8'hE7);
        send_bits(8'hE7, 8);
        send_bits(8'h55, 5);
        vectors++;
        if (bc_m !== 3'd5 || valid_m !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_setup: got bc=%0d v=%b, expected bc=5 v=1", bc_m, valid_m);
        end
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (valid_m !== 1'b0 || dout_m !== 8'h00 || bc_m !== 3'd0 || ready_m !== 1'b1 ||
            valid_l !== 1'b0 || dout_l !== 8'h00 || bc_l !== 3'd0 || ready_l !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_async: got v=%b d=%h bc=%0d r=%b, expected v=0 d=00 bc=0 r=1",
                     valid_m, dout_m, bc_m, ready_m);
        end
        exp_m.delete();
        exp_l.delete();
        @(posedge clk);
        #1;
        rst        = 1'b0;
        dout_ready = 1'b1;
        repeat (10) tick();
        vectors++;
        if (valid_m !== 1'b0 || bc_m !== 3'd0) begin
            miscompares++;
            $display("FAIL rst_no_emit: got v=%b bc=%0d, expected v=0 bc=0", valid_m, bc_m);
        end
    endtask

    initial begin
        rst        = 1'b1;
        din        = 1'b0;
        din_valid  = 1'b0;
        clear      = 1'b0;
        dout_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        test_reset();
        test_msb_first();
        test_lsb_first();
        test_back_to_back();
        test_backpressure();
        test_simultaneous();
        test_clear();
        test_reset_midword();

        vectors++;
        if (exp_m.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_leftover: got %0d words pending, expected 0", exp_m.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sipo_word_collector.md
# sipo_word_collector

Serial-in/parallel-out stage that consumes the single-bit stream produced by the D-latch stage and packs it into WIDTH-bit words. A shift register and bit counter assemble the word. A one-word output buffer with a valid/ready handshake lets assembly continue while the downstream consumer stalls. Backpressure is applied to the serial side only when no storage remains.

## Interface
- WIDTH, 8: word width in bits, legal range 2..32.
- MSB_FIRST, 1: 1 = first accepted bit lands in dout[WIDTH-1]; 0 = first bit lands in dout[0].

- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- din  input  1  serial data bit (the latch q output).
- din_valid  input  1  din carries a bit this cycle.
- din_ready  output  1  stage accepts din this cycle. A bit transfers when din_valid && din_ready.
- clear  input  1  synchronous flush of the partial word. Does not affect the output buffer.
- dout  output  WIDTH  assembled word; stable while dout_valid = 1.
- dout_valid  output  1  output buffer holds a word.
- dout_ready  input  1  consumer takes the word. A word transfers when dout_valid && dout_ready.
- bit_count  output  $clog2(WIDTH)  bits currently held in the shift register (0..WIDTH-1).

## Operation
- Storage:
  - shift register sr[WIDTH-1:0];
  - bit counter cnt;
  - output buffer ob[WIDTH-1:0] with full flag (dout = ob, dout_valid = full).
- Accept (din_valid && din_ready):
  - MSB_FIRST = 1: sr <= {sr[WIDTH-2:0], din}.
  - MSB_FIRST = 0: sr <= {din, sr[WIDTH-1:1]}.
  - cnt increments.
- Completion: an accept with cnt == WIDTH-1 completes the word.
  - The completed value (including the current bit) goes into ob.
  - full <= 1, cnt <= 0, sr <= 0.
- Pop (dout_valid && dout_ready): full <= 0, unless a completion occurs in the same cycle. In that case ob loads the new word and full stays 1.
- Ready rule (combinational): din_ready = !(cnt == WIDTH-1 && full && !dout_ready).
  - Only the final bit of a word stalls, and only when the buffer is occupied and not draining this cycle.
  - din_ready never depends on din_valid.
- Output-buffer state machine:
  - EMPTY -> FULL on completion.
  - FULL -> EMPTY on pop without completion.
  - FULL -> FULL on pop with completion (new word loaded).
  - FULL -> FULL while stalled (no pop).
- clear:
  - cnt <= 0, sr <= 0 in the same cycle; any din accepted that cycle is discarded.
  - Has priority over accept; ob and full are unaffected.
  - din_ready follows the rule above with the pre-clear cnt.
- Width rules:
  - cnt counts 0..WIDTH-1 and wraps to 0 only via completion or clear.
  - bit_count = cnt.

## Timing
- Reset (asynchronous assert, released synchronously by the environment): sr = 0, cnt = 0, ob = 0, full = 0. Hence:
  - dout = 0;
  - dout_valid = 0;
  - bit_count = 0;
  - din_ready = 1.
- Latency: the word appears on dout with dout_valid = 1 the cycle after the edge that accepts its last bit. From the first bit, that is WIDTH accept cycles plus 0 extra cycles.
- Throughput: one bit per cycle sustained when dout_ready = 1 at each completion. Back-to-back words have no bubble.
- dout and dout_valid are registered; there is no combinational path from din to dout.
- Combinational path exists from dout_ready to din_ready only.
- Gaps (din_valid = 0) hold all state.
- Reset mid-word or with full = 1 discards everything immediately; no word is emitted.

## Test plan
- Reset then idle: assert rst mid-word (cnt = 5, full = 1) -> dout_valid = 0, dout = 0, bit_count = 0, din_ready = 1 immediately; no word emitted after release.
- WIDTH = 8, MSB_FIRST = 1, stream 1,0,1,1,0,0,1,0 on consecutive cycles, dout_ready = 1 -> dout = 8'hB2, dout_valid high for exactly 1 cycle, the cycle after the 8th bit.
- MSB_FIRST = 0, same stream -> dout = 8'h4D.
- Backpressure: dout_ready = 0, send 16 bits (0xA5 then 0x3C) -> first word held as 0xA5, 7 bits of the second accepted, din_ready = 0 at cnt = 7. Raise dout_ready -> 0xA5 popped and the 8th bit accepted that cycle; next cycle dout = 0x3C.
- Simultaneous pop and completion: full = 1, dout_ready = 1 on the same edge the last bit is accepted -> dout_valid stays 1, dout changes to the new word, no word lost or duplicated.
- clear: after 3 bits of a word, pulse clear with din_valid = 1 -> bit_count = 0 next cycle, that bit is dropped, and the following 8 bits form a correct word; a held output word is unchanged.
